// File: rtl/seq_divider.sv
// Restoring sequential unsigned divider: one quotient bit per RUN cycle,
// fixed latency, divide-by-zero is flagged and completes without iterating.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] dvd_step;

  // The bit shifted out of rem_q is carried separately: when it is set the
  // shifted value already exceeds any divisor, so no borrow can occur and
  // the low WIDTH bits of the difference are the exact new remainder.
  always_comb begin
    rem_sh   = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    diff     = {1'b0, rem_sh} - {1'b0, dvs_q};
    borrow   = diff[WIDTH] & ~rem_q[WIDTH-1];
    rem_step = borrow ? rem_sh : diff[WIDTH-1:0];
    dvd_step = {dvd_q[WIDTH-2:0], ~borrow};
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rmd_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            dvd_d   = dividend;
            dvs_d   = divisor;
            rem_d   = '0;
            cnt_d   = CW'(WIDTH);
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        rem_d = rem_step;
        dvd_d = dvd_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          quo_d   = dvd_step;
          rmd_d   = rem_step;
          dbz_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    busy        = (state_q == RUN);
    done        = (state_q == DONE);
    quotient    = quo_q;
    remainder   = rmd_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomised and directed checks of seq_divider against a plain-arithmetic
// model of unsigned division with the fixed latency contract.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    if (b == 0) begin
      q = {W{1'b1}};
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  // Pulses start for one edge; afterwards the bench sits in cycle 1.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start = 1'b0;
  endtask

  // Observes until done (bounded); reports its cycle, busy cycles seen and
  // whether the result outputs moved before done.
  task automatic wait_done(input int first_cyc, input bit scramble,
                           output int done_cyc, output int busy_cnt, output bit moved);
    logic [W-1:0] q0, r0;
    logic         z0;
    q0 = quotient;
    r0 = remainder;
    z0 = div_by_zero;
    done_cyc = -1;
    busy_cnt = 0;
    moved    = 1'b0;
    for (int c = first_cyc; c < first_cyc + 200; c++) begin
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
      if (quotient !== q0 || remainder !== r0 || div_by_zero !== z0) moved = 1'b1;
      if (scramble) begin
        dividend = $urandom;
        divisor  = $urandom;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    dividend = 32'd100;
    divisor = 32'd7;
    tick();
    tick();
    start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got=%b exp=0", done); end
    total++; if (quotient !== 0) begin bad++; $display("FAIL reset_q: got=%h exp=0", quotient); end
    total++; if (remainder !== 0) begin bad++; $display("FAIL reset_r: got=%h exp=0", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz: got=%b exp=0", div_by_zero); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int dc, bc;
    bit mv;
    launch(32'd100, 32'd7);
    wait_done(1, 1'b1, dc, bc, mv);
    total++; if (dc !== 33) begin bad++; $display("FAIL basic_done_cycle: got=%0d exp=33", dc); end
    total++; if (bc !== 32) begin bad++; $display("FAIL basic_busy_cycles: got=%0d exp=32", bc); end
    total++; if (quotient !== 32'd14) begin bad++; $display("FAIL basic_q: got=%0d exp=14", quotient); end
    total++; if (remainder !== 32'd2) begin bad++; $display("FAIL basic_r: got=%0d exp=2", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL basic_dbz: got=%b exp=0", div_by_zero); end
    tick();
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_after_done: got done=%b busy=%b exp 0 0", done, busy); end
    total++; if (quotient !== 32'd14 || remainder !== 32'd2) begin bad++; $display("FAIL basic_hold: got q=%0d r=%0d exp 14 2", quotient, remainder); end
  endtask

  task automatic test_extremes();
    logic [W-1:0] av [3];
    logic [W-1:0] bv [3];
    logic [W-1:0] eq, er;
    logic         ez;
    int dc, bc;
    bit mv;
    av[0] = 32'hFFFF_FFFF; bv[0] = 32'd1;
    av[1] = 32'h1234_5678; bv[1] = 32'hFFFF_FFFF;
    av[2] = 32'd0;         bv[2] = 32'd5;
    for (int i = 0; i < 3; i++) begin
      ref_div(av[i], bv[i], eq, er, ez);
      launch(av[i], bv[i]);
      wait_done(1, 1'b1, dc, bc, mv);
      total++; if (dc !== 33) begin bad++; $display("FAIL extreme%0d_done_cycle: got=%0d exp=33", i, dc); end
      total++; if (quotient !== eq) begin bad++; $display("FAIL extreme%0d_q: got=%h exp=%h", i, quotient, eq); end
      total++; if (remainder !== er) begin bad++; $display("FAIL extreme%0d_r: got=%h exp=%h", i, remainder, er); end
      total++; if (div_by_zero !== ez) begin bad++; $display("FAIL extreme%0d_dbz: got=%b exp=%b", i, div_by_zero, ez); end
      tick();
    end
  endtask

  task automatic test_div_by_zero();
    int dc, bc;
    bit mv;
    launch(32'd5, 32'd0);
    wait_done(1, 1'b1, dc, bc, mv);
    total++; if (dc !== 1) begin bad++; $display("FAIL dbz_done_cycle: got=%0d exp=1", dc); end
    total++; if (bc !== 0 || busy !== 1'b0) begin bad++; $display("FAIL dbz_busy: got cycles=%0d busy=%b exp 0 0", bc, busy); end
    total++; if (quotient !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dbz_q: got=%h exp=ffffffff", quotient); end
    total++; if (remainder !== 32'd5) begin bad++; $display("FAIL dbz_r: got=%0d exp=5", remainder); end
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag: got=%b exp=1", div_by_zero); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL dbz_pulse: got=%b exp=0", done); end
  endtask

  task automatic test_start_while_busy();
    int dc, bc;
    bit mv;
    launch(32'd50, 32'd3);
    for (int i = 1; i < 10; i++) tick();
    start = 1'b1;
    dividend = 32'd9;
    divisor = 32'd9;
    tick();
    start = 1'b0;
    wait_done(11, 1'b1, dc, bc, mv);
    total++; if (dc !== 33) begin bad++; $display("FAIL busy_start_done_cycle: got=%0d exp=33", dc); end
    total++; if (mv !== 1'b0) begin bad++; $display("FAIL busy_start_outputs_held: got moved=%b exp=0", mv); end
    total++; if (quotient !== 32'd16 || remainder !== 32'd2) begin bad++; $display("FAIL busy_start_result: got q=%0d r=%0d exp 16 2", quotient, remainder); end
    tick();
  endtask

  task automatic test_back_to_back();
    int dc, bc;
    bit mv;
    start = 1'b1;
    dividend = 32'd50;
    divisor = 32'd3;
    tick();
    dividend = 32'd81;
    divisor = 32'd9;
    wait_done(1, 1'b0, dc, bc, mv);
    total++; if (dc !== 33) begin bad++; $display("FAIL b2b_first_cycle: got=%0d exp=33", dc); end
    total++; if (quotient !== 32'd16 || remainder !== 32'd2) begin bad++; $display("FAIL b2b_first_result: got q=%0d r=%0d exp 16 2", quotient, remainder); end
    tick();
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_rerun: got busy=%b exp=1", busy); end
    wait_done(34, 1'b1, dc, bc, mv);
    total++; if (dc !== 66) begin bad++; $display("FAIL b2b_second_cycle: got=%0d exp=66", dc); end
    total++; if (quotient !== 32'd9 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin bad++; $display("FAIL b2b_second_result: got q=%0d r=%0d z=%b exp 9 0 0", quotient, remainder, div_by_zero); end
    tick();
  endtask

  task automatic test_reset_mid();
    int dc, bc, seen;
    bit mv;
    launch(32'd100, 32'd7);
    for (int i = 1; i < 15; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rstmid_ctrl: got busy=%b done=%b exp 0 0", busy, done); end
    total++; if (quotient !== 0 || remainder !== 0 || div_by_zero !== 1'b0) begin bad++; $display("FAIL rstmid_outputs: got q=%h r=%h z=%b exp 0 0 0", quotient, remainder, div_by_zero); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      tick();
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_idle: got active cycles=%0d exp=0", seen); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    launch(32'd100, 32'd7);
    wait_done(1, 1'b1, dc, bc, mv);
    total++; if (dc !== 33) begin bad++; $display("FAIL rstmid_rerun_cycle: got=%0d exp=33", dc); end
    total++; if (quotient !== 32'd14 || remainder !== 32'd2) begin bad++; $display("FAIL rstmid_rerun_result: got q=%0d r=%0d exp 14 2", quotient, remainder); end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, eq, er;
    logic         ez;
    int dc, bc, edc;
    bit mv;
    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = $urandom;
        default: b = a >> $urandom_range(0, 31);
      endcase
      ref_div(a, b, eq, er, ez);
      edc = (b == 0) ? 1 : W + 1;
      launch(a, b);
      wait_done(1, 1'b1, dc, bc, mv);
      total++; if (dc !== edc) begin bad++; $display("FAIL rand%0d_done_cycle: got=%0d exp=%0d", n, dc, edc); end
      total++; if (bc !== edc - 1) begin bad++; $display("FAIL rand%0d_busy_cycles: got=%0d exp=%0d", n, bc, edc - 1); end
      total++; if (mv !== 1'b0) begin bad++; $display("FAIL rand%0d_held: got moved=%b exp=0", n, mv); end
      total++; if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
        bad++;
        $display("FAIL rand%0d_result %h/%h: got q=%h r=%h z=%b exp q=%h r=%h z=%b",
                 n, a, b, quotient, remainder, div_by_zero, eq, er, ez);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_div_by_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a division; sampled only in IDLE or DONE.
REQ-005 The block SHALL have port dividend, input, WIDTH bits: unsigned numerator; captured on an accepted start.
REQ-006 The block SHALL have port divisor, input, WIDTH bits: unsigned denominator; captured on an accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: high exactly one cycle, in DONE, when a result is valid.
REQ-009 The block SHALL have port quotient, output, WIDTH bits: registered quotient result.
REQ-010 The block SHALL have port remainder, output, WIDTH bits: registered remainder result.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: registered flag for a zero divisor on the last completed operation.

Function
REQ-012 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-013 The block SHALL accept start only in IDLE or DONE; start in RUN SHALL be ignored, with no effect on the operation in progress.
REQ-014 On an accepted start with divisor != 0, the block SHALL capture both operands, clear a WIDTH-bit partial remainder, load an iteration counter with WIDTH, and enter RUN.
REQ-015 On an accepted start with divisor == 0, the block SHALL enter DONE on the next edge.
REQ-016 A zero-divisor result SHALL be: quotient all ones, remainder = dividend, div_by_zero = 1.
REQ-017 Each RUN cycle SHALL perform one restoring step:
  - shift {partial remainder, dividend register} left by 1;
  - trial-subtract divisor from the shifted partial remainder using a WIDTH+1-bit difference;
  - no borrow: keep the difference and shift quotient bit 1 into the LSB;
  - borrow: restore the partial remainder and shift in 0.
REQ-018 The counter SHALL decrement once per RUN cycle; after the WIDTH-th step the block SHALL enter DONE.
REQ-019 On entering DONE, the block SHALL update quotient, remainder and div_by_zero together; div_by_zero = 0 for a nonzero divisor.
REQ-020 Latency SHALL be fixed, with an accepted start at edge 0:
  - nonzero divisor: busy high cycles 1..WIDTH, done high cycle WIDTH+1;
  - zero divisor: busy never high, done high cycle 1.
REQ-021 The block SHALL leave DONE after one cycle:
  - start high in DONE: accepted, next state RUN (or DONE again for a zero divisor);
  - start low in DONE: next state IDLE.
REQ-022 quotient, remainder and div_by_zero SHALL hold their last values until the next DONE entry and SHALL NOT change during RUN.
REQ-023 Operand inputs SHALL be ignored except on the cycle a start is accepted.
REQ-024 No intermediate value SHALL overflow: the partial remainder is always less than the divisor after each step.

Reset
REQ-025 When rst is high at a clock edge, the block SHALL enter IDLE with busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 and the internal counter cleared.
REQ-026 rst SHALL take priority over start and SHALL abort a RUN in progress without asserting done.
REQ-027 After rst deasserts, the first start SHALL be accepted on the next edge.

Verification
REQ-028 Basic division: dividend=100, divisor=7, start at cycle 0 -> busy on cycles 1-32; done on cycle 33 with quotient=14, remainder=2, div_by_zero=0.
REQ-029 Extremes: 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0. 0x12345678/0xFFFFFFFF -> q=0, r=0x12345678. 0/5 -> q=0, r=0. Each with done at cycle 33.
REQ-030 Divide by zero: dividend=5, divisor=0 -> done on cycle 1, q=0xFFFFFFFF, r=5, div_by_zero=1, busy never high.
REQ-031 Start while busy: start 50/3, then at cycle 10 apply start with 9/9 -> ignored; cycle 33 gives q=16, r=2.
REQ-032 Back-to-back: start held high with 50/3 then 81/9 -> done cycle 33 (q=16, r=2); the second op is accepted in that DONE cycle; done cycle 66 (q=9, r=0).
REQ-033 Reset mid-operation: rst at cycle 15 of a division -> outputs all 0 and state IDLE next cycle, no done pulse; a new 100/7 then completes normally in 33 cycles.
